store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Posted-store buffer between the CPU writeback path and the memory bus: the opposite direction of the register-bank load path, which consumes memory read data. Register store data is queued in a small FIFO, and the pipeline continues while entries drain to memory one at a time over a start/done handshake. Loads check the buffer by address; when a queued store matches, its data is forwarded so the load never returns stale memory contents.

## Interface
- DEPTH, 4, number of entries; power of two, range 2..16
- ADDR_W, 27, memory word-address width
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- st_valid  in  1  store request from CPU this cycle
- st_addr  in  ADDR_W  store word address
- st_data  in  32  store data (register B value)
- st_ready  out  1  buffer can accept a store; equals count < DEPTH
- ld_addr  in  ADDR_W  address of the load being checked
- ld_hit  out  1  combinational; some queued entry matches ld_addr
- ld_q  out  32  combinational; data of the youngest matching entry, 0 when no hit
- empty  out  1  count == 0
- bus_start  out  1  registered one-cycle pulse that starts a memory write
- bus_we  out  1  registered; high from the bus_start cycle until the cycle bus_done is seen
- bus_addr  out  ADDR_W  registered head address; stable while bus_we is high
- bus_data  out  32  registered head data; stable while bus_we is high

## Operation
- FIFO storage: DEPTH entries plus head pointer, tail pointer and count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: occurs when st_valid && st_ready at a clock edge. The tail entry is written and tail advances. With st_valid while st_ready=0, the request is ignored; the CPU is required to stall.
- Pop: occurs at the edge where bus_done is sampled high in ISSUE or WAIT. head advances.
- Push and pop on the same edge: count is unchanged and both take effect. st_ready is derived from the registered count only, so a full buffer refuses a push even on a pop edge.
- FSM states:
  - IDLE: bus_start=0, bus_we=0. When count>0, load bus_addr/bus_data from the head entry and go to ISSUE.
  - ISSUE: bus_start=1, bus_we=1. If bus_done, pop and go to IDLE; otherwise go to WAIT.
  - WAIT: bus_start=0, bus_we=1. If bus_done, pop and go to IDLE; otherwise stay in WAIT.
- bus_done sampled in IDLE is ignored.
- Forwarding:
  - All entries between head and tail are compared with ld_addr.
  - The youngest match, closest to tail, drives ld_q.
  - The entry currently being written to memory stays visible until its pop edge.
  - A store accepted in the same cycle is not visible until the next cycle.
- Reset (any time, including mid-transfer): count=0, head=tail=0, state=IDLE, all entries discarded. Memory may see a truncated write; the system resets the memory controller on the same reset.

## Timing
- Reset values: st_ready=1, empty=1, ld_hit=0, ld_q=0, bus_start=0, bus_we=0, bus_addr=0, bus_data=0.
- Store accepted at edge N: empty=0 after N; state=ISSUE after edge N+1; bus_start high for the one cycle between edges N+1 and N+2.
- Minimum per-store memory occupancy: 2 cycles (ISSUE with bus_done, then IDLE). Back-to-back queued stores give a bus_start every 2 cycles when memory answers immediately.
- bus_done is required to be a single-cycle pulse. A bus_done held high across IDLE into the next ISSUE is treated as completion of the new store.
- ld_hit and ld_q: combinational from ld_addr and the registered buffer contents; zero-cycle latency; no path from st_* inputs.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release, run 10 idle cycles -> st_ready=1, empty=1, bus_start never 1, bus_we=0.
- Single store: push addr 0x0000100, data 0xDEADBEEF at edge N; bus_done=1 in the first bus_start cycle -> bus_start high exactly one cycle after edge N+1, with bus_addr=0x0000100 and bus_data=0xDEADBEEF; empty=1 two cycles later.
- Fill to full: push 4 stores with bus_done held 0 -> st_ready=0 after the 4th push; a 5th st_valid is ignored. Send one bus_done -> st_ready=1. Drain order matches push order.
- Forwarding with duplicate address: push (0x20, 0x11111111), (0x30, 0x22222222), (0x20, 0x33333333).
  - ld_addr=0x20 -> ld_hit=1, ld_q=0x33333333.
  - ld_addr=0x40 -> ld_hit=0, ld_q=0.
- Simultaneous push and pop at count=2: st_valid high on the bus_done edge -> count stays 2, the new entry lands at the correct tail, no entry is lost, and pointers wrap after 4 further stores.
- Reset mid-transfer: 3 entries queued, state WAIT, assert reset asynchronously mid-cycle -> bus_we=0 and empty=1 immediately without waiting for clk; after release no bus_start occurs.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// ---------------------------------------------------------------------------
// store_write_buffer_if
//
// Bundles the CPU store port, the load-forwarding lookup port and the memory
// write port of the posted-store buffer.
//
//   st_valid/st_addr/st_data -> buffer   store request from the CPU
//   st_ready                 <- buffer   buffer can accept a store
//   ld_addr                  -> buffer   address of the load being checked
//   ld_hit/ld_q              <- buffer   forwarding result (combinational)
//   empty                    <- buffer   no store queued
//   bus_start/bus_we         <- buffer   memory write start pulse / write active
//   bus_addr/bus_data        <- buffer   address/data of the store being written
//   bus_done                 -> buffer   memory write completion pulse
//
// Modports: master = CPU/memory environment, slave = the buffer itself.
// ---------------------------------------------------------------------------
interface store_write_buffer_if #(
    parameter int ADDR_W = 27
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_ready;

    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [31:0]       ld_q;

    logic              empty;

    logic              bus_start;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_data;
    logic              bus_done;

    modport master (
        output st_valid, st_addr, st_data, ld_addr, bus_done,
        input  st_ready, ld_hit, ld_q, empty,
               bus_start, bus_we, bus_addr, bus_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, bus_done,
        output st_ready, ld_hit, ld_q, empty,
               bus_start, bus_we, bus_addr, bus_data
    );
endinterface

// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
//
// Posted-store buffer between the CPU writeback path and the memory bus.
// Stores are queued in a DEPTH-entry FIFO and drained to memory one at a time
// over a start/done handshake. Loads look the buffer up by address and get
// the data of the youngest queued store to the same word, so they never see
// stale memory contents.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous active-low reset, clears all state immediately
//   sb     store_write_buffer_if.slave (store, load-lookup and memory ports)
//
// Parameters:
//   DEPTH   number of entries, power of two, 2..16
//   ADDR_W  memory word-address width
// ---------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;

    state_t            state_reg;
    state_t            state_next;

    logic              bus_start_reg;
    logic              bus_we_reg;
    logic [ADDR_W-1:0] bus_addr_reg;
    logic [31:0]       bus_data_reg;

    logic              push;
    logic              pop;
    logic              load_head;

    // st_ready comes from the registered count only, so a full buffer
    // refuses a store even on the edge where an entry drains.
    assign sb.st_ready = (count_reg < CNT_W'(DEPTH));
    assign sb.empty    = (count_reg == '0);
    assign push        = sb.st_valid && sb.st_ready;

    // Entry payloads carry no reset: an entry is only meaningful while it
    // lies between head and tail, and those pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= sb.st_addr;
            data_mem[tail_reg] <= sb.st_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = sb.bus_done ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (sb.bus_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Drain FSM: output / control decode
    // ------------------------------------------------------------------
    // bus_done only completes a transfer that is actually in flight; a done
    // seen in IDLE is ignored.
    always_comb begin
        load_head = 1'b0;
        pop       = 1'b0;
        case (state_reg)
            S_IDLE:  load_head = (count_reg != '0);
            S_ISSUE: pop       = sb.bus_done;
            S_WAIT:  pop       = sb.bus_done;
            default: begin
                load_head = 1'b0;
                pop       = 1'b0;
            end
        endcase
    end

    // Bus outputs are flops: start/we mirror the state being entered, and the
    // head entry is captured once so address/data stay put during the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_start_reg <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_data_reg  <= '0;
        end else begin
            bus_start_reg <= (state_next == S_ISSUE);
            bus_we_reg    <= (state_next != S_IDLE);
            if (load_head) begin
                bus_addr_reg <= addr_mem[head_reg];
                bus_data_reg <= data_mem[head_reg];
            end
        end
    end

    assign sb.bus_start = bus_start_reg;
    assign sb.bus_we    = bus_we_reg;
    assign sb.bus_addr  = bus_addr_reg;
    assign sb.bus_data  = bus_data_reg;

    // ------------------------------------------------------------------
    // Load forwarding
    // ------------------------------------------------------------------
    // age = distance of an entry from head; an entry is live when its age is
    // below count. The head entry (being written) stays live until its pop.
    logic [PTR_W-1:0] age [DEPTH];
    logic [DEPTH-1:0] match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
        assign age[gi]   = PTR_W'(gi) - head_reg;
        assign match[gi] = ({1'b0, age[gi]} < count_reg) &&
                           (addr_mem[gi] == sb.ld_addr);
    end

    // Youngest match = largest age among matching live entries.
    logic             fwd_hit;
    logic [31:0]      fwd_q;
    logic [PTR_W-1:0] best_age;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_q    = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i] && (!fwd_hit || (age[i] >= best_age))) begin
                fwd_hit  = 1'b1;
                best_age = age[i];
                fwd_q    = data_mem[i];
            end
        end
    end

    assign sb.ld_hit = fwd_hit;
    assign sb.ld_q   = fwd_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_write_buffer
//
// Self-checking bench for store_write_buffer: a reference model (queue of
// pending stores plus a transfer phase) is checked every cycle, alongside a
// table of hand-computed vectors and directed corner-case sequences.
// ---------------------------------------------------------------------------
module tb_store_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 27;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    store_write_buffer_if #(.ADDR_W(ADDR_W)) sif ();

    store_write_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sif)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    entry_t            mq[$];          // pending stores, oldest first
    int                m_phase;        // 0: no transfer, 1: first cycle, 2: later cycles
    logic [ADDR_W-1:0] m_bus_addr;
    logic [31:0]       m_bus_data;
    bit                m_push;
    bit                m_pop;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] started[$];     // bus_addr seen at each bus_start

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase    = 0;
        m_bus_addr = '0;
        m_bus_data = '0;
    endtask

    // Effect of one clock edge given the inputs sampled at that edge.
    task automatic model_edge(input logic v, input logic [ADDR_W-1:0] a,
                              input logic [31:0] d, input logic done);
        entry_t e;
        m_pop  = (m_phase != 0) && done;
        m_push = v && (mq.size() < DEPTH);
        if (m_phase == 0) begin
            if (mq.size() > 0) begin
                m_phase    = 1;
                m_bus_addr = mq[0].addr;
                m_bus_data = mq[0].data;
            end
        end else if (done) begin
            m_phase = 0;
        end else begin
            m_phase = 2;
        end
        if (m_pop) begin
            e = mq.pop_front();
        end
        if (m_push) begin
            e.addr = a;
            e.data = d;
            mq.push_back(e);
        end
    endtask

    task automatic model_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [31:0] q);
        hit = 1'b0;
        q   = '0;
        foreach (mq[i]) begin
            if (mq[i].addr == a) begin
                hit = 1'b1;
                q   = mq[i].data;
            end
        end
    endtask

    task automatic check_model();
        logic        e_hit;
        logic [31:0] e_q;
        model_fwd(sif.ld_addr, e_hit, e_q);
        chk("st_ready",  sif.st_ready,  (mq.size() < DEPTH));
        chk("empty",     sif.empty,     (mq.size() == 0));
        chk("bus_start", sif.bus_start, (m_phase == 1));
        chk("bus_we",    sif.bus_we,    (m_phase != 0));
        chk("bus_addr",  sif.bus_addr,  m_bus_addr);
        chk("bus_data",  sif.bus_data,  m_bus_data);
        chk("ld_hit",    sif.ld_hit,    e_hit);
        chk("ld_q",      sif.ld_q,      e_q);
    endtask

    // One clock cycle: drive inputs, take the edge, check 1 time unit later.
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic done, input logic [ADDR_W-1:0] la);
        sif.st_valid = v;
        sif.st_addr  = a;
        sif.st_data  = d;
        sif.bus_done = done;
        sif.ld_addr  = la;
        @(posedge clk);
        model_edge(v, a, d, done);
        #1;
        check_model();
        if (sif.bus_start) begin
            started.push_back(sif.bus_addr);
        end
        $display("txn t=%0t v=%0d a=%h d=%h done=%0d push=%0d pop=%0d depth=%0d",
                 $time, v, a, d, done, m_push, m_pop, mq.size());
    endtask

    task automatic idle_cycle(input logic done);
        cycle(1'b0, '0, '0, done, '0);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              done;
        logic [ADDR_W-1:0] ld;
        logic              e_ready;
        logic              e_empty;
        logic              e_start;
        logic              e_we;
        logic [ADDR_W-1:0] e_baddr;
        logic [31:0]       e_bdata;
        logic              e_hit;
        logic [31:0]       e_q;
    } vec_t;

    vec_t tbl[11];

    logic [ADDR_W-1:0] exp_order[$];

    initial begin
        int guard;
        int pushed;

        tbl[0]  = '{1'b1, 27'h20, 32'h11111111, 1'b0, 27'h20, 1'b1, 1'b0, 1'b0, 1'b0, 27'h00, 32'h00000000, 1'b1, 32'h11111111};
        tbl[1]  = '{1'b1, 27'h30, 32'h22222222, 1'b0, 27'h20, 1'b1, 1'b0, 1'b1, 1'b1, 27'h20, 32'h11111111, 1'b1, 32'h11111111};
        tbl[2]  = '{1'b1, 27'h20, 32'h33333333, 1'b0, 27'h20, 1'b1, 1'b0, 1'b0, 1'b1, 27'h20, 32'h11111111, 1'b1, 32'h33333333};
        tbl[3]  = '{1'b0, 27'h00, 32'h00000000, 1'b0, 27'h40, 1'b1, 1'b0, 1'b0, 1'b1, 27'h20, 32'h11111111, 1'b0, 32'h00000000};
        tbl[4]  = '{1'b0, 27'h00, 32'h00000000, 1'b0, 27'h30, 1'b1, 1'b0, 1'b0, 1'b1, 27'h20, 32'h11111111, 1'b1, 32'h22222222};
        tbl[5]  = '{1'b0, 27'h00, 32'h00000000, 1'b1, 27'h20, 1'b1, 1'b0, 1'b0, 1'b0, 27'h20, 32'h11111111, 1'b1, 32'h33333333};
        tbl[6]  = '{1'b0, 27'h00, 32'h00000000, 1'b0, 27'h20, 1'b1, 1'b0, 1'b1, 1'b1, 27'h30, 32'h22222222, 1'b1, 32'h33333333};
        tbl[7]  = '{1'b0, 27'h00, 32'h00000000, 1'b1, 27'h30, 1'b1, 1'b0, 1'b0, 1'b0, 27'h30, 32'h22222222, 1'b0, 32'h00000000};
        tbl[8]  = '{1'b0, 27'h00, 32'h00000000, 1'b0, 27'h20, 1'b1, 1'b0, 1'b1, 1'b1, 27'h20, 32'h33333333, 1'b1, 32'h33333333};
        tbl[9]  = '{1'b0, 27'h00, 32'h00000000, 1'b1, 27'h20, 1'b1, 1'b1, 1'b0, 1'b0, 27'h20, 32'h33333333, 1'b0, 32'h00000000};
        tbl[10] = '{1'b0, 27'h00, 32'h00000000, 1'b1, 27'h20, 1'b1, 1'b1, 1'b0, 1'b0, 27'h20, 32'h33333333, 1'b0, 32'h00000000};

        sif.st_valid = 1'b0;
        sif.st_addr  = '0;
        sif.st_data  = '0;
        sif.bus_done = 1'b0;
        sif.ld_addr  = '0;
        model_reset();

        // --- Reset then idle -------------------------------------------
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.st_ready",  sif.st_ready,  1'b1);
        chk("rst.empty",     sif.empty,     1'b1);
        chk("rst.ld_hit",    sif.ld_hit,    1'b0);
        chk("rst.ld_q",      sif.ld_q,      32'h0);
        chk("rst.bus_start", sif.bus_start, 1'b0);
        chk("rst.bus_we",    sif.bus_we,    1'b0);
        chk("rst.bus_addr",  sif.bus_addr,  32'h0);
        chk("rst.bus_data",  sif.bus_data,  32'h0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle_cycle(1'b0);
            chk("idle.bus_start", sif.bus_start, 1'b0);
        end

        // --- Table: forwarding with duplicate address and drain --------
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].ld);
            chk($sformatf("tbl%0d.st_ready", i),  sif.st_ready,  tbl[i].e_ready);
            chk($sformatf("tbl%0d.empty", i),     sif.empty,     tbl[i].e_empty);
            chk($sformatf("tbl%0d.bus_start", i), sif.bus_start, tbl[i].e_start);
            chk($sformatf("tbl%0d.bus_we", i),    sif.bus_we,    tbl[i].e_we);
            chk($sformatf("tbl%0d.bus_addr", i),  sif.bus_addr,  tbl[i].e_baddr);
            chk($sformatf("tbl%0d.bus_data", i),  sif.bus_data,  tbl[i].e_bdata);
            chk($sformatf("tbl%0d.ld_hit", i),    sif.ld_hit,    tbl[i].e_hit);
            chk($sformatf("tbl%0d.ld_q", i),      sif.ld_q,      tbl[i].e_q);
        end

        // --- Single store ----------------------------------------------
        // A store offered this cycle must not forward before its edge.
        sif.st_valid = 1'b1;
        sif.st_addr  = 27'h0000100;
        sif.st_data  = 32'hDEADBEEF;
        sif.ld_addr  = 27'h0000100;
        #1;
        chk("same_cycle.ld_hit", sif.ld_hit, 1'b0);
        cycle(1'b1, 27'h0000100, 32'hDEADBEEF, 1'b0, 27'h0000100);   // edge N
        chk("single.N.bus_start", sif.bus_start, 1'b0);
        chk("single.N.empty",     sif.empty,     1'b0);
        idle_cycle(1'b0);                                            // edge N+1
        chk("single.N1.bus_start", sif.bus_start, 1'b1);
        chk("single.N1.bus_addr",  sif.bus_addr,  32'h0000100);
        chk("single.N1.bus_data",  sif.bus_data,  32'hDEADBEEF);
        idle_cycle(1'b1);                                            // edge N+2
        chk("single.N2.bus_start", sif.bus_start, 1'b0);
        chk("single.N2.bus_we",    sif.bus_we,    1'b0);
        chk("single.N2.empty",     sif.empty,     1'b1);

        // --- Fill to full ----------------------------------------------
        started.delete();
        exp_order.delete();
        for (int i = 0; i < 4; i++) begin
            exp_order.push_back(27'h300 + 27'(i));
            cycle(1'b1, 27'h300 + 27'(i), $urandom, 1'b0, '0);
        end
        chk("full.st_ready", sif.st_ready, 1'b0);
        cycle(1'b1, 27'h355, 32'h55555555, 1'b0, 27'h355);
        chk("full.ignored.ld_hit", sif.ld_hit, 1'b0);
        chk("full.ignored.st_ready", sif.st_ready, 1'b0);
        idle_cycle(1'b1);
        chk("full.pop.st_ready", sif.st_ready, 1'b1);
        guard = 0;
        while (!(sif.empty && !sif.bus_we) && guard < 40) begin
            idle_cycle(sif.bus_we);
            guard++;
        end
        chk("full.drain_timeout", (guard < 40), 1'b1);
        chk("full.order.count", started.size(), exp_order.size());
        foreach (exp_order[i]) begin
            if (i < started.size()) begin
                chk($sformatf("full.order%0d", i), started[i], exp_order[i]);
            end
        end

        // --- Simultaneous push and pop at count=2 ----------------------
        started.delete();
        exp_order.delete();
        exp_order.push_back(27'h200);
        exp_order.push_back(27'h201);
        exp_order.push_back(27'h202);
        cycle(1'b1, 27'h200, 32'hA0A0A0A0, 1'b0, '0);
        cycle(1'b1, 27'h201, 32'hA1A1A1A1, 1'b0, '0);
        chk("simul.pre.bus_start", sif.bus_start, 1'b1);
        cycle(1'b1, 27'h202, 32'hA2A2A2A2, 1'b1, 27'h202);
        chk("simul.empty",   sif.empty,  1'b0);
        chk("simul.ld_hit",  sif.ld_hit, 1'b1);
        chk("simul.ld_q",    sif.ld_q,   32'hA2A2A2A2);
        chk("simul.depth",   mq.size(),  2);
        pushed = 0;
        guard  = 0;
        while (pushed < 4 && guard < 40) begin
            if (sif.st_ready) begin
                exp_order.push_back(27'h210 + 27'(pushed));
                cycle(1'b1, 27'h210 + 27'(pushed), $urandom, sif.bus_we, 27'h201);
                pushed++;
            end else begin
                idle_cycle(sif.bus_we);
            end
            guard++;
        end
        chk("simul.push_timeout", (guard < 40), 1'b1);
        guard = 0;
        while (!(sif.empty && !sif.bus_we) && guard < 40) begin
            idle_cycle(sif.bus_we);
            guard++;
        end
        chk("simul.drain_timeout", (guard < 40), 1'b1);
        chk("simul.order.count", started.size(), exp_order.size());
        foreach (exp_order[i]) begin
            if (i < started.size()) begin
                chk($sformatf("simul.order%0d", i), started[i], exp_order[i]);
            end
        end

        // --- Reset mid-transfer ----------------------------------------
        cycle(1'b1, 27'h400, 32'h40404040, 1'b0, '0);
        cycle(1'b1, 27'h401, 32'h41414141, 1'b0, '0);
        cycle(1'b1, 27'h402, 32'h42424242, 1'b0, '0);
        chk("midrst.pre.bus_we", sif.bus_we, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst.bus_we",    sif.bus_we,    1'b0);
        chk("midrst.empty",     sif.empty,     1'b1);
        chk("midrst.st_ready",  sif.st_ready,  1'b1);
        chk("midrst.bus_start", sif.bus_start, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle_cycle(1'b0);
            chk("midrst.after.bus_start", sif.bus_start, 1'b0);
        end

        // --- Randomized traffic against the model ----------------------
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  27'($urandom_range(0, 7)),
                  $urandom,
                  ($urandom_range(0, 2) == 0),
                  27'($urandom_range(0, 7)));
        end
        guard = 0;
        while (!(sif.empty && !sif.bus_we) && guard < 60) begin
            idle_cycle(sif.bus_we);
            guard++;
        end
        chk("rand.drain_timeout", (guard < 60), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
